mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store access sequencer between the MEM stage and a data memory.
// A misaligned access is split into two word beats; the pipeline is stalled until the access completes.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [1:0]  i_memSize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  input  logic        i_memReady,
  input  logic [31:0] i_memReadData,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [31:0] o_memAddr,
  output logic [3:0]  o_memByteEn,
  output logic [31:0] o_memWriteData,
  output logic        o_stall,
  output logic [31:0] o_readData,
  output logic        o_fault
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t      state, state_nxt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] beat1_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [CW-1:0] wait_cnt;

  logic [1:0]  off;
  logic [4:0]  sh_bits;
  logic [2:0]  nbytes;
  logic [3:0]  mask_n;
  logic [7:0]  lane_mask;
  logic [63:0] wdata_sh;
  logic [31:0] first_addr;
  logic        split;
  logic        timeout;
  logic [31:0] load_lo;
  logic [31:0] load_hi;
  logic [31:0] load_mask;
  logic [31:0] load_word;

  // Access geometry, derived from the captured request only.
  always_comb begin
    off = addr_q[1:0];
    sh_bits = {off, 3'b000};
    unique case (size_q)
      2'b00:   begin nbytes = 3'd1; mask_n = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask_n = 4'b0011; end
      default: begin nbytes = 3'd4; mask_n = 4'b1111; end
    endcase
    lane_mask  = {4'b0000, mask_n} << off;
    wdata_sh   = {32'h0, wdata_q} << sh_bits;
    first_addr = {addr_q[31:2], 2'b00};
    split      = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    load_mask  = {{8{mask_n[3]}}, {8{mask_n[2]}}, {8{mask_n[1]}}, {8{mask_n[0]}}};
  end

  // Load assembly: the low word comes from beat 1 (held in beat1_q once a second beat is running).
  always_comb begin
    load_lo = (state == ACC2) ? beat1_q : i_memReadData;
    load_hi = (state == ACC2) ? i_memReadData : 32'h0;
    load_word = ((load_lo >> sh_bits) | (load_hi << (6'd32 - {1'b0, sh_bits}))) & load_mask;
  end

  assign timeout = (wait_cnt == CW'(TIMEOUT - 1)) && !i_memReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output and next-state term gets a default before the case, so no latch can be inferred.
  always_comb begin
    state_nxt      = state;
    o_memReq       = 1'b0;
    o_memWrite     = 1'b0;
    o_memAddr      = 32'h0;
    o_memByteEn    = 4'b0000;
    o_memWriteData = 32'h0;
    o_stall        = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by reset so the stall drops the instant reset is asserted.
        o_stall = i_req && !reset;
        if (i_req) state_nxt = ACC1;
      end
      ACC1: begin
        o_memReq       = 1'b1;
        o_memWrite     = wr_q;
        o_memAddr      = first_addr;
        o_memByteEn    = lane_mask[3:0];
        o_memWriteData = wdata_sh[31:0];
        o_stall        = 1'b1;
        if (i_memReady)   state_nxt = split ? ACC2 : DONE;
        else if (timeout) state_nxt = DONE;
      end
      ACC2: begin
        o_memReq       = 1'b1;
        o_memWrite     = wr_q;
        o_memAddr      = first_addr + 32'd4;
        o_memByteEn    = lane_mask[7:4];
        o_memWriteData = wdata_sh[63:32];
        o_stall        = 1'b1;
        if (i_memReady || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      beat1_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      fault_q <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (i_req) begin
            wr_q    <= i_write;
            size_q  <= i_memSize;
            addr_q  <= i_addr;
            wdata_q <= i_writeData;
            rdata_q <= 32'h0;
          end
        end
        ACC1, ACC2: begin
          if (i_memReady) begin
            wait_cnt <= '0;
            if (state == ACC1 && split) beat1_q <= i_memReadData;
            else                        rdata_q <= wr_q ? 32'h0 : load_word;
          end else if (timeout) begin
            wait_cnt <= '0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE:    rdata_q <= 32'h0;
        default: rdata_q <= 32'h0;
      endcase
    end
  end

  assign o_readData = rdata_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected beats and results are queued when a request is
// driven and popped as the DUT presents beats and reaches its completion cycle.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic        i_write;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr;
  logic [31:0] i_writeData;
  logic        i_memReady;
  logic [31:0] i_memReadData;
  logic        o_memReq;
  logic        o_memWrite;
  logic [31:0] o_memAddr;
  logic [3:0]  o_memByteEn;
  logic [31:0] o_memWriteData;
  logic        o_stall;
  logic [31:0] o_readData;
  logic        o_fault;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_write        (i_write),
    .i_memSize      (i_memSize),
    .i_addr         (i_addr),
    .i_writeData    (i_writeData),
    .i_memReady     (i_memReady),
    .i_memReadData  (i_memReadData),
    .o_memReq       (o_memReq),
    .o_memWrite     (o_memWrite),
    .o_memAddr      (o_memAddr),
    .o_memByteEn    (o_memByteEn),
    .o_memWriteData (o_memWriteData),
    .o_stall        (o_stall),
    .o_readData     (o_readData),
    .o_fault        (o_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } result_t;

  beat_t   beat_q[$];
  result_t res_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic push_beat(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    beat_t b;
    b.write = w; b.addr = a; b.be = be; b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic push_res(input logic [31:0] rd, input logic flt);
    result_t r;
    r.rdata = rd; r.fault = flt;
    res_q.push_back(r);
  endtask

  // Drives one request from IDLE, answers beats (or withholds ready), and checks DONE and the return to IDLE.
  task automatic run_access(input string tag, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input bit ready, input int exp_req_cycles);
    int      req_cycles = 0;
    int      beat_idx   = 0;
    int      guard      = 0;
    beat_t   eb;
    result_t er;
    i_req = 1'b1; i_write = wr; i_memSize = size; i_addr = addr; i_writeData = wdata; i_memReady = 1'b0;
    #1 check({tag, ".idle_stall"}, {31'b0, o_stall}, 32'd1);
    @(posedge clk); @(negedge clk);
    i_req = 1'b0; i_write = 1'($urandom); i_memSize = 2'($urandom);
    i_addr = $urandom; i_writeData = $urandom;
    #1;
    while (o_memReq === 1'b1 && guard < 40) begin
      if (beat_q.size() == 0) begin
        check({tag, ".extra_beat"}, {31'b0, o_memReq}, 32'd0);
        break;
      end
      eb = beat_q[0];
      check({tag, ".addr"},  o_memAddr, eb.addr);
      check({tag, ".be"},    {28'b0, o_memByteEn}, {28'b0, eb.be});
      check({tag, ".wdata"}, o_memWriteData, eb.data);
      check({tag, ".write"}, {31'b0, o_memWrite}, {31'b0, eb.write});
      check({tag, ".stall"}, {31'b0, o_stall}, 32'd1);
      req_cycles++;
      if (ready) begin
        i_memReady = 1'b1;
        i_memReadData = (beat_idx == 0) ? rd1 : rd2;
      end
      @(posedge clk); @(negedge clk);
      if (ready) begin
        void'(beat_q.pop_front());
        beat_idx++;
      end
      i_memReady = 1'b0; i_memReadData = $urandom;
      #1;
      guard++;
    end
    check({tag, ".req_cycles"}, req_cycles, exp_req_cycles);
    if (!ready) beat_q.delete();
    check({tag, ".beats_left"}, beat_q.size(), 32'd0);
    if (res_q.size() != 0) begin
      er = res_q.pop_front();
      check({tag, ".rdata"}, o_readData, er.rdata);
      check({tag, ".fault"}, {31'b0, o_fault}, {31'b0, er.fault});
    end
    // A request presented during DONE must not be taken.
    i_req = 1'b1;
    #1 check({tag, ".done_stall"}, {31'b0, o_stall}, 32'd0);
    @(posedge clk); @(negedge clk);
    i_req = 1'b0;
    #1;
    check({tag, ".idle_req"},   {31'b0, o_memReq}, 32'd0);
    check({tag, ".idle_fault"}, {31'b0, o_fault}, 32'd0);
    check({tag, ".idle_rdata"}, o_readData, 32'd0);
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b1; i_write = 1'b1; i_memSize = 2'b10;
    i_addr = 32'h1234_5678; i_writeData = 32'hFFFF_FFFF; i_memReady = 1'b1; i_memReadData = 32'hFFFF_FFFF;
    #2;
    check("rst.req",   {31'b0, o_memReq}, 32'd0);
    check("rst.stall", {31'b0, o_stall}, 32'd0);
    check("rst.addr",  o_memAddr, 32'd0);
    check("rst.rdata", o_readData, 32'd0);
    check("rst.fault", {31'b0, o_fault}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; i_req = 1'b0; i_memReady = 1'b0;
    #1 check("post_rst.stall", {31'b0, o_stall}, 32'd0);

    push_beat(1'b0, 32'h0000_1000, 4'b1111, 32'h0);
    push_res(32'hDEAD_BEEF, 1'b0);
    run_access("ld_word", 1'b0, 2'b10, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1);

    push_beat(1'b1, 32'h0000_1000, 4'b1000, 32'hA500_0000);
    push_res(32'h0, 1'b0);
    run_access("st_byte", 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0, 32'h0, 1'b1, 1);

    push_beat(1'b0, 32'h0000_1000, 4'b1000, 32'h0);
    push_beat(1'b0, 32'h0000_1004, 4'b0001, 32'h0);
    push_res(32'h0000_8811, 1'b0);
    run_access("ld_half_split", 1'b0, 2'b01, 32'h0000_1003, 32'h0, 32'h1122_3344, 32'h5566_7788, 1'b1, 2);

    push_beat(1'b1, 32'h0000_2000, 4'b1100, 32'hCCDD_0000);
    push_beat(1'b1, 32'h0000_2004, 4'b0011, 32'h0000_AABB);
    push_res(32'h0, 1'b0);
    run_access("st_word_split", 1'b1, 2'b10, 32'h0000_2002, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b1, 2);

    push_beat(1'b0, 32'h0000_1000, 4'b0010, 32'h0);
    push_res(32'h0000_00CC, 1'b0);
    run_access("ld_byte", 1'b0, 2'b00, 32'h0000_1001, 32'h0, 32'hAABB_CCDD, 32'h0, 1'b1, 1);

    push_beat(1'b1, 32'h0000_3000, 4'b1100, 32'h1234_0000);
    push_res(32'h0, 1'b0);
    run_access("st_half_hi", 1'b1, 2'b01, 32'h0000_3002, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 1);

    push_beat(1'b1, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
    push_res(32'h0, 1'b0);
    run_access("st_size11", 1'b1, 2'b11, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1, 1);

    push_beat(1'b0, 32'hFFFF_FFFC, 4'b1100, 32'h0);
    push_beat(1'b0, 32'h0000_0000, 4'b0011, 32'h0);
    push_res(32'h7788_1122, 1'b0);
    run_access("ld_wrap", 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 32'h1122_3344, 32'h5566_7788, 1'b1, 2);

    push_beat(1'b0, 32'h0000_5000, 4'b1111, 32'h0);
    push_res(32'h0, 1'b1);
    run_access("timeout", 1'b0, 2'b10, 32'h0000_5000, 32'h0, 32'h0, 32'h0, 1'b0, TIMEOUT);

    // Reset asserted mid-cycle while the second beat of a split load waits for ready.
    i_req = 1'b1; i_write = 1'b0; i_memSize = 2'b01; i_addr = 32'h0000_1003; i_writeData = 32'h0;
    @(posedge clk); @(negedge clk);
    i_req = 1'b0; i_memReady = 1'b1; i_memReadData = 32'h1122_3344;
    @(posedge clk); @(negedge clk);
    i_memReady = 1'b0;
    #1 check("rst_acc2.addr", o_memAddr, 32'h0000_1004);
    #2 reset = 1'b1;
    #1;
    check("rst_acc2.req",   {31'b0, o_memReq}, 32'd0);
    check("rst_acc2.stall", {31'b0, o_stall}, 32'd0);
    check("rst_acc2.addr0", o_memAddr, 32'd0);
    check("rst_acc2.be",    {28'b0, o_memByteEn}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_acc2.idle", {31'b0, o_memReq}, 32'd0);
    beat_q.delete(); res_q.delete();

    push_beat(1'b0, 32'h0000_6000, 4'b0100, 32'h0);
    push_res(32'h0000_0022, 1'b0);
    run_access("after_rst", 1'b0, 2'b00, 32'h0000_6002, 32'h0, 32'h1122_3344, 32'h0, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
